// File: rtl/ps2_key_queue.sv
// PS/2 byte-stream decoder: folds E0/F0 prefixes into {brk,ext,code} events, queued in a FWFT FIFO.
// Latency: byte strobe on edge N -> event visible (ev_valid/level) after edge N; proto_err registered.
// Backpressure: ev_valid/ev_ready drain; full FIFO drops new events (sticky overflow) unless popped same cycle.

module ps2_key_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    output logic                   wr_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    input  logic                   rd_rdy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rd_vld = ~empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_rdy = ~full | rd_rdy;
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_en  = rd_vld & rd_rdy;
    assign rd_dat = mem[rd_ptr_q[AW-1:0]];
    assign level  = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end
endmodule

module ps2_key_queue #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             key_data,
    input  logic                   key_valid,
    output logic                   ev_valid,
    output logic [9:0]             ev_data,
    input  logic                   ev_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   proto_err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          proto_err_q, proto_err_d;
    logic          overflow_q, overflow_d;

    logic          is_e0;
    logic          is_f0;
    logic          is_prefix;
    logic          tmo;
    logic          push_vld;
    ev_t           push_dat;
    logic          fifo_wr_rdy;
    logic          drop;

    assign is_e0     = (key_data == 8'hE0);
    assign is_f0     = (key_data == 8'hF0);
    assign is_prefix = is_e0 | is_f0;
    // A byte on the expiry cycle takes priority over the timeout.
    assign tmo       = ~key_valid && (timer_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            proto_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            proto_err_q <= proto_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid && is_e0) begin
                    state_d = ST_EXT;
                end else if (key_valid && is_f0) begin
                    state_d = ST_BRK;
                end
            end
            ST_EXT: begin
                if (key_valid) begin
                    if (is_f0) begin
                        state_d = ST_EXTBRK;
                    end else if (!is_e0) begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_BRK, ST_EXTBRK: begin
                if (key_valid || tmo) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push_vld      = key_valid & ~is_prefix;
        push_dat.brk  = (state_q == ST_BRK) || (state_q == ST_EXTBRK);
        push_dat.ext  = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
        push_dat.code = key_data;
        proto_err_d   = 1'b0;
        case (state_q)
            ST_IDLE:           proto_err_d = 1'b0;
            ST_EXT:            proto_err_d = tmo;
            ST_BRK, ST_EXTBRK: proto_err_d = (key_valid & is_prefix) | tmo;
            default:           proto_err_d = 1'b0;
        endcase
    end

    assign drop       = push_vld & ~fifo_wr_rdy;
    assign overflow_d = drop | (overflow_q & ~ovf_clr);

    ps2_key_fifo #(
        .W     (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (push_vld),
        .wr_dat  (push_dat),
        .wr_rdy  (fifo_wr_rdy),
        .rd_vld  (ev_valid),
        .rd_dat  (ev_data),
        .rd_rdy  (ev_ready),
        .level   (level)
    );

    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_ps2_key_queue.sv
// Randomized + directed bench for ps2_key_queue with a queue-based reference model and scoreboard.
module tb_ps2_key_queue;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] key_data;
    logic       key_valid;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr;
    logic       proto_err;

    ps2_key_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_data  (key_data),
        .key_valid (key_valid),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ev_ready  (ev_ready),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: prefix flags plus a count of queued events.
    logic [9:0] exp_q[$];
    int         m_cnt;
    bit         m_ovf;
    bit         m_err;
    bit         m_in_pfx;
    bit         m_ext;
    bit         m_brk;
    int         m_wait;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt = 0; m_ovf = 0; m_err = 0;
        m_in_pfx = 0; m_ext = 0; m_brk = 0; m_wait = 0;
    endtask

    task automatic model_edge(input bit kv, input logic [7:0] kd, input bit rdy, input bit clr);
        bit         pop;
        bit         push;
        bit         drop;
        logic [9:0] ev;
        pop  = rdy && (m_cnt > 0);
        push = 0;
        drop = 0;
        ev   = '0;
        m_err = 0;
        if (kv) begin
            m_wait = 0;
            if (!m_in_pfx) begin
                if (kd == 8'hE0) begin m_in_pfx = 1; m_ext = 1; m_brk = 0; end
                else if (kd == 8'hF0) begin m_in_pfx = 1; m_ext = 0; m_brk = 1; end
                else begin push = 1; ev = {2'b00, kd}; end
            end else if (!m_brk) begin
                if (kd == 8'hF0) m_brk = 1;
                else if (kd != 8'hE0) begin push = 1; ev = {2'b01, kd}; m_in_pfx = 0; end
            end else begin
                m_in_pfx = 0;
                if (kd == 8'hE0 || kd == 8'hF0) m_err = 1;
                else begin push = 1; ev = {1'b1, m_ext, kd}; end
            end
        end else if (m_in_pfx) begin
            if (m_wait == TIMEOUT - 1) begin m_err = 1; m_in_pfx = 0; m_wait = 0; end
            else m_wait++;
        end
        if (push) begin
            if (m_cnt == DEPTH && !pop) drop = 1;
            else begin exp_q.push_back(ev); m_cnt++; end
        end
        if (pop) m_cnt--;
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic step(input bit kv, input logic [7:0] kd, input bit rdy, input bit clr);
        key_valid = kv; key_data = kd; ev_ready = rdy; ovf_clr = clr;
        @(posedge clk);
        model_edge(kv, kd, rdy, clr);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
    endtask

    // Monitor: compares outputs mid-cycle and retires the head when the consumer pops it.
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            check("level", level, m_cnt);
            check("overflow", overflow, m_ovf);
            check("proto_err", proto_err, m_err);
            check("ev_valid", ev_valid, m_cnt != 0);
            if (ev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ev_unexpected: got %0h expected none at %0t", ev_data, $time);
                end else begin
                    check("ev_data", ev_data, exp_q[0]);
                    if (ev_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset_n = 0; key_valid = 0; key_data = 0; ev_ready = 0; ovf_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ev_valid", ev_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_proto_err", proto_err, 0);
        reset_n = 1;
        mon_en  = 1;
        idle(2, 0);

        // Single make code
        step(1, 8'h1C, 0, 0);
        check("make_valid", ev_valid, 1);
        check("make_data", ev_data, 10'h01C);
        check("make_level", level, 1);
        idle(3, 1);

        // Extended make, extended break, plain break
        step(1, 8'hE0, 0, 0); step(1, 8'h75, 0, 0);
        step(1, 8'hE0, 0, 0); step(1, 8'hF0, 0, 0); step(1, 8'h75, 0, 0);
        step(1, 8'hF0, 0, 0); step(1, 8'h1C, 0, 0);
        check("seq_level", level, 3);
        check("seq_head", ev_data, 10'h175);
        step(0, 8'h00, 1, 0);
        check("seq_second", ev_data, 10'h375);
        step(0, 8'h00, 1, 0);
        check("seq_third", ev_data, 10'h21C);
        idle(3, 1);

        // Fill, overflow, clear, then simultaneous push/pop at full
        for (int i = 0; i < DEPTH; i++) step(1, 8'h10 + 8'(i), 0, 0);
        step(1, 8'h55, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, DEPTH);
        check("ovf_head", ev_data, 10'h010);
        step(0, 8'h00, 0, 1);
        check("ovf_clr", overflow, 0);
        step(1, 8'h66, 1, 0);
        check("full_pp_level", level, DEPTH);
        check("full_pp_ovf", overflow, 0);
        check("full_pp_head", ev_data, 10'h011);
        idle(DEPTH + 4, 1);
        check("drained", level, 0);

        // Overflow set and clear on the same edge: overflow wins
        for (int i = 0; i < DEPTH; i++) step(1, 8'h20, 0, 0);
        step(1, 8'h21, 0, 1);
        check("ovf_wins", overflow, 1);
        step(0, 8'h00, 0, 1);
        idle(DEPTH + 2, 1);

        // Double break prefix
        step(1, 8'hF0, 0, 0); step(1, 8'hF0, 0, 0);
        check("err_pulse", proto_err, 1);
        step(0, 8'h00, 0, 0);
        check("err_clear", proto_err, 0);
        check("err_nopush", level, 0);

        // Prefix timeout
        step(1, 8'hE0, 0, 0);
        idle(TIMEOUT - 1, 0);
        check("tmo_early", proto_err, 0);
        step(0, 8'h00, 0, 0);
        check("tmo_pulse", proto_err, 1);
        step(1, 8'h1C, 0, 0);
        check("tmo_after", ev_data, 10'h01C);

        // Byte on the expiry cycle wins over the timeout
        step(1, 8'hF0, 0, 0);
        idle(TIMEOUT - 1, 0);
        step(1, 8'h2A, 0, 0);
        check("tmo_race_err", proto_err, 0);
        check("tmo_race_lvl", level, 2);

        // Reset mid-prefix with 3 queued
        step(1, 8'h33, 0, 0);
        step(1, 8'hE0, 0, 0);
        check("pre_rst_level", level, 3);
        reset_n = 0;
        #1;
        check("arst_valid", ev_valid, 0);
        check("arst_level", level, 0);
        model_reset();
        key_valid = 1; key_data = 8'h1C;
        repeat (2) @(posedge clk);
        #1;
        key_valid = 0;
        reset_n = 1;
        step(1, 8'h1C, 0, 0);
        check("post_rst_data", ev_data, 10'h01C);
        idle(3, 1);

        // Random traffic
        begin
            int rdy_pct;
            rdy_pct = 50;
            for (int n = 0; n < 3000; n++) begin
                logic [7:0] b;
                int r;
                if (n % 200 == 0) rdy_pct = $urandom_range(5, 95);
                r = $urandom_range(0, 9);
                if (r < 2) b = 8'hE0;
                else if (r < 4) b = 8'hF0;
                else b = 8'($urandom);
                if ($urandom_range(0, 99) < 2) idle(TIMEOUT + 2, $urandom_range(0, 99) < rdy_pct);
                step($urandom_range(0, 99) < 40, b, $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 99) < 3);
            end
        end

        idle(TIMEOUT + DEPTH + 4, 1);
        check("final_level", level, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
